regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  RV32I integer register file: the consumer end of the write-back interface (W_* bus).
//  Commits retiring results from the write-back latch into x1..x31.
//  Serves two combinational read ports to decode, with same-cycle write bypass.
//  Keeps the retirement counters (cycle, instret) and the last-retired PC/instruction for debug/CSR.
// PARAMETERS
//  REG_NUM    32  architectural registers; x0 hardwired to zero; address width = 5
//  COUNTER_W  64  width of CYCLE and INSTRET counters
// PORTS
//  CLK           in   1          clock; all state updates on posedge
//  RST           in   1          synchronous reset, active-high
//  STALL         in   1          pipeline stall; blocks commit and instret increment
//  W_PC          in   32         PC of the instruction in write-back
//  W_INST        in   32         instruction word in write-back
//  W_VALID       in   1          write-back slot holds a real instruction
//  W_REG_D       in   5          destination register index
//  W_REG_D_V     in   32         destination value
//  D_REG_S1      in   5          decode read port 1 address
//  D_REG_S2      in   5          decode read port 2 address
//  D_REG_S1_V    out  32         read data port 1 (combinational)
//  D_REG_S2_V    out  32         read data port 2 (combinational)
//  CYCLE         out  COUNTER_W  cycles since reset
//  INSTRET       out  COUNTER_W  instructions retired since reset
//  RET_PC        out  32         PC of most recently retired instruction
//  RET_INST      out  32         instruction word of most recently retired instruction
// BEHAVIOUR
//  - commit = W_VALID & ~STALL. Write enable we = commit & (W_REG_D != 0).
//  - Reset (RST=1 at posedge): all regs x1..x31 <= 0; CYCLE, INSTRET, RET_PC, RET_INST <= 0.
//    RST dominates STALL and commit in the same cycle. Reset mid-stream discards the W_* slot.
//  - Write: on posedge with we=1, regs[W_REG_D] <= W_REG_D_V. Latency 1 cycle to array.
//  - Read: D_REG_Sn_V = 0 if D_REG_Sn == 0;
//          else W_REG_D_V if we & (D_REG_Sn == W_REG_D)   (write-through bypass, same cycle);
//          else regs[D_REG_Sn]. Pure combinational; no read latency.
//  - Both ports may address the same register, or the write target, in one cycle; both bypass.
//  - Writes to x0 are dropped, but still count as retirement (commit, not we, drives INSTRET).
//  - STALL: the W latch holds its contents while STALL=1. Regfile must not re-commit: no write,
//    no INSTRET increment, RET_* held. The held slot commits exactly once, on the first
//    non-stalled edge.
//  - CYCLE: +1 every posedge when not in reset, independent of STALL. Wraps all-ones -> 0.
//  - INSTRET: +1 on posedge when commit=1. Wraps all-ones -> 0. Arithmetic modulo 2^COUNTER_W.
//  - RET_PC/RET_INST <= W_PC/W_INST on commit; otherwise held.
//  - Bubbles (W_VALID=0, e.g. after a flush in write-back) change nothing except CYCLE.
//  - No X propagation: array fully initialised by reset; outputs defined from the first
//    post-reset cycle.
// STRUCTURE
//  - Shared package/header: REG_ADDR_W=5, REG_ZERO=5'd0, XLEN=32, COUNTER_W default.
//    Same constants used by decode and the forwarding unit.
//  - One sub-module: rf_counter (COUNTER_W-bit, sync reset, inc enable, wraps);
//    instantiated twice (CYCLE: inc=1, INSTRET: inc=commit).
//  - Array + bypass mux inline in regfile.
// TESTING
//  1 Reset: RST=1 two cycles, then read all 32 addrs -> all 0; CYCLE=0 then 1 after first free edge.
//  2 Write/read: commit x5<=32'hDEADBEEF; next cycle D_REG_S1=5 -> 32'hDEADBEEF; INSTRET=1, RET_PC=W_PC.
//  3 Bypass: W_VALID=1, W_REG_D=7, W_REG_D_V=32'h1234, D_REG_S1=D_REG_S2=7 same cycle
//    -> both ports 32'h1234 before the edge.
//  4 x0: commit W_REG_D=0, V=32'hFFFFFFFF -> read x0 = 0 (also in same cycle, no bypass); INSTRET +1.
//  5 Stall: W_VALID=1 held 3 cycles with STALL=1, then STALL=0 -> reg written once, INSTRET +1 only,
//    CYCLE +4.
//  6 Wrap/reset race: force INSTRET to 2^64-1, commit -> 0; RST=1 with commit to x3=32'h55 -> x3 stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared RV32I register-file constants, also used by decode and the
// forwarding unit so that every stage agrees on address width and the
// hardwired-zero register. Also provides the read-port selection helper.
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int REG_NUM_DEF   = 32;
  localparam int COUNTER_W_DEF = 64;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Read-port value: x0 reads zero, a same-cycle write to the addressed
  // register is forwarded, otherwise the stored array entry is returned.
  function automatic logic [XLEN-1:0] read_port(
    input logic [REG_ADDR_W-1:0] rd_addr,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] wr_addr,
    input logic [XLEN-1:0]       wr_data,
    input logic [XLEN-1:0]       arr_data
  );
    logic [XLEN-1:0] val;
    if (rd_addr == REG_ZERO) begin
      val = {XLEN{1'b0}};
    end else if (we && (rd_addr == wr_addr)) begin
      val = wr_data;
    end else begin
      val = arr_data;
    end
    return val;
  endfunction

endpackage

// File: rtl/regfile_rf_counter.sv
// ----------------------------------------------------------------------------
// rf_counter
// Free-running W-bit counter with synchronous active-high reset and an
// increment enable. Wraps from all-ones back to zero (modulo 2^W).
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous reset, active-high (dominates inc)
//   inc   in  1  increment enable
//   count out W  current count
// ----------------------------------------------------------------------------
module rf_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment when enabled, natural wrap on overflow.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// RV32I integer register file at the consumer end of the write-back bus.
// Commits retiring results into x1..x31, serves two combinational read
// ports to decode with same-cycle write bypass, and keeps CYCLE/INSTRET
// counters plus the last retired PC and instruction word.
// Ports:
//   CLK, RST (sync, active-high), STALL
//   W_PC, W_INST, W_VALID, W_REG_D, W_REG_D_V   write-back slot
//   D_REG_S1, D_REG_S2 -> D_REG_S1_V, D_REG_S2_V  combinational reads
//   CYCLE, INSTRET (COUNTER_W), RET_PC, RET_INST  retirement state
// ----------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int COUNTER_W = COUNTER_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STALL,
  input  logic [XLEN-1:0]       W_PC,
  input  logic [XLEN-1:0]       W_INST,
  input  logic                  W_VALID,
  input  logic [REG_ADDR_W-1:0] W_REG_D,
  input  logic [XLEN-1:0]       W_REG_D_V,
  input  logic [REG_ADDR_W-1:0] D_REG_S1,
  input  logic [REG_ADDR_W-1:0] D_REG_S2,
  output logic [XLEN-1:0]       D_REG_S1_V,
  output logic [XLEN-1:0]       D_REG_S2_V,
  output logic [COUNTER_W-1:0]  CYCLE,
  output logic [COUNTER_W-1:0]  INSTRET,
  output logic [XLEN-1:0]       RET_PC,
  output logic [XLEN-1:0]       RET_INST
);

  logic commit_s;
  logic we_s;

  logic [XLEN-1:0] regs_q [REG_NUM];
  logic [XLEN-1:0] regs_d [REG_NUM];
  logic [XLEN-1:0] ret_pc_q;
  logic [XLEN-1:0] ret_pc_d;
  logic [XLEN-1:0] ret_inst_q;
  logic [XLEN-1:0] ret_inst_d;

  // A held (stalled) slot must not commit; it commits on the first free edge.
  assign commit_s = W_VALID & ~STALL;
  // x0 writes are dropped but still retire.
  assign we_s     = commit_s & (W_REG_D != REG_ZERO);

  // Next array contents: at most one entry updated per cycle.
  always_comb begin
    regs_d = regs_q;
    if (we_s) begin
      regs_d[W_REG_D] = W_REG_D_V;
    end else begin
      regs_d = regs_q;
    end
  end

  // Next retirement debug state: captured only on commit.
  always_comb begin
    ret_pc_d   = ret_pc_q;
    ret_inst_d = ret_inst_q;
    if (commit_s) begin
      ret_pc_d   = W_PC;
      ret_inst_d = W_INST;
    end else begin
      ret_pc_d   = ret_pc_q;
      ret_inst_d = ret_inst_q;
    end
  end

  // Array and retirement registers; reset clears every entry so no X leaks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      ret_pc_q   <= {XLEN{1'b0}};
      ret_inst_q <= {XLEN{1'b0}};
    end else begin
      regs_q     <= regs_d;
      ret_pc_q   <= ret_pc_d;
      ret_inst_q <= ret_inst_d;
    end
  end

  // Combinational read ports with write-through bypass.
  always_comb begin
    D_REG_S1_V = read_port(D_REG_S1, we_s, W_REG_D, W_REG_D_V, regs_q[D_REG_S1]);
    D_REG_S2_V = read_port(D_REG_S2, we_s, W_REG_D, W_REG_D_V, regs_q[D_REG_S2]);
  end

  rf_counter #(.W(COUNTER_W)) u_cycle (
    .clk   (CLK),
    .rst   (RST),
    .inc   (1'b1),
    .count (CYCLE)
  );

  rf_counter #(.W(COUNTER_W)) u_instret (
    .clk   (CLK),
    .rst   (RST),
    .inc   (commit_s),
    .count (INSTRET)
  );

  assign RET_PC   = ret_pc_q;
  assign RET_INST = ret_inst_q;

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile
// Directed self-checking bench for regfile. A second instance with 4-bit
// counters shares all inputs so counter wrap-around is reachable quickly.
// ----------------------------------------------------------------------------
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_valid;
  logic [4:0]  w_rd;
  logic [31:0] w_v;
  logic [4:0]  s1;
  logic [4:0]  s2;
  logic [31:0] s1_v;
  logic [31:0] s2_v;
  logic [63:0] cycle;
  logic [63:0] instret;
  logic [31:0] ret_pc;
  logic [31:0] ret_inst;

  logic [31:0] s1_v4;
  logic [31:0] s2_v4;
  logic [3:0]  cyc4;
  logic [3:0]  inst4;
  logic [31:0] ret_pc4;
  logic [31:0] ret_inst4;

  int tests_run;
  int fail_cnt;

  regfile u_dut (
    .CLK        (clk),
    .RST        (rst),
    .STALL      (stall),
    .W_PC       (w_pc),
    .W_INST     (w_inst),
    .W_VALID    (w_valid),
    .W_REG_D    (w_rd),
    .W_REG_D_V  (w_v),
    .D_REG_S1   (s1),
    .D_REG_S2   (s2),
    .D_REG_S1_V (s1_v),
    .D_REG_S2_V (s2_v),
    .CYCLE      (cycle),
    .INSTRET    (instret),
    .RET_PC     (ret_pc),
    .RET_INST   (ret_inst)
  );

  regfile #(.COUNTER_W(4)) u_small (
    .CLK        (clk),
    .RST        (rst),
    .STALL      (stall),
    .W_PC       (w_pc),
    .W_INST     (w_inst),
    .W_VALID    (w_valid),
    .W_REG_D    (w_rd),
    .W_REG_D_V  (w_v),
    .D_REG_S1   (s1),
    .D_REG_S2   (s2),
    .D_REG_S1_V (s1_v4),
    .D_REG_S2_V (s2_v4),
    .CYCLE      (cyc4),
    .INSTRET    (inst4),
    .RET_PC     (ret_pc4),
    .RET_INST   (ret_inst4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; w_valid = 1'b0;
    w_pc = 32'h0; w_inst = 32'h0; w_rd = 5'd0; w_v = 32'h0; s1 = 5'd0; s2 = 5'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (cycle !== 64'd0 || instret !== 64'd0) begin
      fail_cnt++; $display("FAIL reset_counters: cycle=%0d instret=%0d, required 0 0", cycle, instret);
    end
    tests_run++;
    if (ret_pc !== 32'h0 || ret_inst !== 32'h0) begin
      fail_cnt++; $display("FAIL reset_ret: pc=%h inst=%h, required 0 0", ret_pc, ret_inst);
    end
    tick();
    tests_run++;
    if (cycle !== 64'd1) begin
      fail_cnt++; $display("FAIL reset_cycle1: cycle=%0d, required 1", cycle);
    end
    for (int i = 0; i < 32; i++) begin
      s1 = i[4:0];
      s2 = 5'(31 - i);
      #1;
      tests_run++;
      if (s1_v !== 32'h0 || s2_v !== 32'h0) begin
        fail_cnt++; $display("FAIL reset_read x%0d: s1=%h s2=%h, required 0", i, s1_v, s2_v);
      end
    end
  endtask

  task automatic test_write_read();
    logic [63:0] i0;
    tick();
    i0 = instret;
    w_valid = 1'b1; w_rd = 5'd5; w_v = 32'hDEADBEEF; w_pc = 32'h0000_0100; w_inst = 32'h0050_0293;
    tick();
    w_valid = 1'b0; s1 = 5'd5; s2 = 5'd6;
    #1;
    tests_run++;
    if (s1_v !== 32'hDEADBEEF || s2_v !== 32'h0) begin
      fail_cnt++; $display("FAIL write_read: s1=%h s2=%h, required deadbeef 0", s1_v, s2_v);
    end
    tests_run++;
    if (instret !== i0 + 64'd1) begin
      fail_cnt++; $display("FAIL write_instret: got %0d, required %0d", instret, i0 + 64'd1);
    end
    tests_run++;
    if (ret_pc !== 32'h0000_0100 || ret_inst !== 32'h0050_0293) begin
      fail_cnt++; $display("FAIL write_ret: pc=%h inst=%h, required 00000100 00500293", ret_pc, ret_inst);
    end
  endtask

  task automatic test_bypass();
    w_valid = 1'b1; w_rd = 5'd7; w_v = 32'h0000_1234; w_pc = 32'h104; w_inst = 32'h13;
    s1 = 5'd7; s2 = 5'd7;
    #1;
    tests_run++;
    if (s1_v !== 32'h0000_1234 || s2_v !== 32'h0000_1234) begin
      fail_cnt++; $display("FAIL bypass_both: s1=%h s2=%h, required 00001234", s1_v, s2_v);
    end
    // A stalled slot is not a write, so it must not be forwarded.
    stall = 1'b1;
    #1;
    tests_run++;
    if (s1_v !== 32'h0) begin
      fail_cnt++; $display("FAIL bypass_stalled: s1=%h, required 0", s1_v);
    end
    stall = 1'b0;
    tick();
    w_valid = 1'b0; s2 = 5'd5;
    #1;
    tests_run++;
    if (s1_v !== 32'h0000_1234 || s2_v !== 32'hDEADBEEF) begin
      fail_cnt++; $display("FAIL bypass_array: s1=%h s2=%h, required 00001234 deadbeef", s1_v, s2_v);
    end
  endtask

  task automatic test_x0();
    logic [63:0] i0;
    i0 = instret;
    w_valid = 1'b1; w_rd = 5'd0; w_v = 32'hFFFF_FFFF; w_pc = 32'h108; w_inst = 32'hFFF0_0013;
    s1 = 5'd0; s2 = 5'd0;
    #1;
    tests_run++;
    if (s1_v !== 32'h0 || s2_v !== 32'h0) begin
      fail_cnt++; $display("FAIL x0_same_cycle: s1=%h s2=%h, required 0", s1_v, s2_v);
    end
    tick();
    w_valid = 1'b0;
    #1;
    tests_run++;
    if (s1_v !== 32'h0 || instret !== i0 + 64'd1 || ret_pc !== 32'h108) begin
      fail_cnt++; $display("FAIL x0_commit: x0=%h instret=%0d pc=%h, required 0 %0d 108", s1_v, instret, ret_pc, i0 + 64'd1);
    end
  endtask

  task automatic test_stall();
    logic [63:0] c0;
    logic [63:0] i0;
    tick();
    c0 = cycle; i0 = instret;
    w_valid = 1'b1; stall = 1'b1; w_rd = 5'd9; w_v = 32'hAAAA_5555; w_pc = 32'h200; w_inst = 32'h0000_0493;
    s1 = 5'd9;
    tick(); tick(); tick();
    tests_run++;
    if (instret !== i0 || ret_pc !== 32'h108 || s1_v !== 32'h0) begin
      fail_cnt++; $display("FAIL stall_hold: instret=%0d pc=%h x9=%h, required %0d 108 0", instret, ret_pc, s1_v, i0);
    end
    stall = 1'b0;
    tick();
    w_valid = 1'b0;
    #1;
    tests_run++;
    if (instret !== i0 + 64'd1 || cycle !== c0 + 64'd4) begin
      fail_cnt++; $display("FAIL stall_counts: instret=%0d cycle=%0d, required %0d %0d", instret, cycle, i0 + 64'd1, c0 + 64'd4);
    end
    tests_run++;
    if (s1_v !== 32'hAAAA_5555 || ret_pc !== 32'h200) begin
      fail_cnt++; $display("FAIL stall_commit: x9=%h pc=%h, required aaaa5555 200", s1_v, ret_pc);
    end
    tick();
    tests_run++;
    if (instret !== i0 + 64'd1) begin
      fail_cnt++; $display("FAIL stall_once: instret=%0d, required %0d", instret, i0 + 64'd1);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; w_valid = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0; w_valid = 1'b1; w_rd = 5'd10; w_pc = 32'h300; w_inst = 32'h33;
    for (int k = 1; k <= 15; k++) begin
      w_v = k;
      tick();
    end
    tests_run++;
    if (inst4 !== 4'hF || cyc4 !== 4'hF || instret !== 64'd15) begin
      fail_cnt++; $display("FAIL wrap_pre: inst4=%0d cyc4=%0d instret=%0d, required 15 15 15", inst4, cyc4, instret);
    end
    w_v = 32'd16;
    tick();
    w_valid = 1'b0; s1 = 5'd10;
    #1;
    tests_run++;
    if (inst4 !== 4'h0 || cyc4 !== 4'h0) begin
      fail_cnt++; $display("FAIL wrap_small: inst4=%0d cyc4=%0d, required 0 0", inst4, cyc4);
    end
    tests_run++;
    if (instret !== 64'd16 || s1_v !== 32'd16) begin
      fail_cnt++; $display("FAIL wrap_main: instret=%0d x10=%0d, required 16 16", instret, s1_v);
    end
  endtask

  task automatic test_reset_race();
    w_valid = 1'b1; w_rd = 5'd31; w_v = 32'h0000_CAFE; w_pc = 32'h400; w_inst = 32'h77;
    tick();
    w_rd = 5'd3; w_v = 32'h0000_0077;
    tick();
    rst = 1'b1; w_v = 32'h0000_0055; w_pc = 32'h404;
    tick(); tick();
    rst = 1'b0; w_valid = 1'b0; s1 = 5'd3; s2 = 5'd31;
    #1;
    tests_run++;
    if (s1_v !== 32'h0 || s2_v !== 32'h0) begin
      fail_cnt++; $display("FAIL race_regs: x3=%h x31=%h, required 0 0", s1_v, s2_v);
    end
    tests_run++;
    if (instret !== 64'd0 || cycle !== 64'd0 || ret_pc !== 32'h0 || ret_inst !== 32'h0) begin
      fail_cnt++; $display("FAIL race_state: instret=%0d cycle=%0d pc=%h inst=%h, required all 0", instret, cycle, ret_pc, ret_inst);
    end
  endtask

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_stall();
    test_wrap();
    test_reset_race();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
